// File: rtl/axil_reg_responder_if.sv
// AXI4-Lite bus bundle between an initiator and the register responder.
// The initiator drives valids, addresses and data. The responder drives readies and responses.
interface axil_reg_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_responder.sv
// AXI4-Lite responder backed by a small register array.
// The write path and the read path are independent. Each path allows one outstanding transaction, and every response is OKAY.
module axil_reg_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  axil_reg_responder_if.slave s_axil
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W      = ADDR_WIDTH - ADDR_LSB;
  localparam int DEPTH      = 2 ** IDX_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  aw_held_reg;
  logic                  w_held_reg;
  logic                  awready_reg;
  logic                  wready_reg;
  logic                  bvalid_reg;
  logic [IDX_W-1:0]      waddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_WIDTH-1:0] wstrb_reg;
  logic                  arready_reg;
  logic                  rvalid_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  commit;
  logic [IDX_W-1:0]      commit_idx;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [STRB_WIDTH-1:0] commit_strb;
  logic [IDX_W-1:0]      ar_idx;

  // The low address bits only select a byte within a word, so they are intentionally left unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axil.awaddr[ADDR_LSB-1:0], s_axil.araddr[ADDR_LSB-1:0]};

  assign aw_hs = s_axil.awvalid && awready_reg;
  assign w_hs  = s_axil.wvalid && wready_reg;
  assign b_hs  = bvalid_reg && s_axil.bready;
  assign ar_hs = s_axil.arvalid && arready_reg;
  assign r_hs  = rvalid_reg && s_axil.rready;

  // A write commits on the first edge where both address and data are available.
  // Each of them may already be held or may be completing its handshake on this edge.
  assign commit      = (aw_held_reg || aw_hs) && (w_held_reg || w_hs) && !bvalid_reg;
  assign commit_idx  = aw_held_reg ? waddr_reg : s_axil.awaddr[ADDR_WIDTH-1:ADDR_LSB];
  assign commit_data = w_held_reg ? wdata_reg : s_axil.wdata;
  assign commit_strb = w_held_reg ? wstrb_reg : s_axil.wstrb;
  assign ar_idx      = s_axil.araddr[ADDR_WIDTH-1:ADDR_LSB];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (commit_strb[i]) begin
          mem[commit_idx][i*8 +: 8] <= commit_data[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awready_reg <= 1'b1;
      wready_reg  <= 1'b1;
      bvalid_reg  <= 1'b0;
      waddr_reg   <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else if (b_hs) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awready_reg <= 1'b1;
      wready_reg  <= 1'b1;
      bvalid_reg  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_reg <= 1'b1;
        awready_reg <= 1'b0;
        waddr_reg   <= s_axil.awaddr[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_held_reg <= 1'b1;
        wready_reg <= 1'b0;
        wdata_reg  <= s_axil.wdata;
        wstrb_reg  <= s_axil.wstrb;
      end
      if (commit) begin
        bvalid_reg <= 1'b1;
      end
    end
  end

  // The read samples the array before this edge's commit lands, so a read to the word being written returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      arready_reg <= 1'b1;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else if (ar_hs) begin
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b1;
      rdata_reg   <= mem[ar_idx];
    end else if (r_hs) begin
      arready_reg <= 1'b1;
      rvalid_reg  <= 1'b0;
    end
  end

  assign s_axil.awready = awready_reg;
  assign s_axil.wready  = wready_reg;
  assign s_axil.bvalid  = bvalid_reg;
  assign s_axil.bresp   = 2'b00;
  assign s_axil.arready = arready_reg;
  assign s_axil.rvalid  = rvalid_reg;
  assign s_axil.rdata   = rdata_reg;
  assign s_axil.rresp   = 2'b00;
endmodule

// File: tb/tb_axil_reg_responder.sv
// Self-checking bench for axil_reg_responder.
// Expected read data and write responses are queued when a transaction is issued, and a monitor pops and compares them as the DUT responds.
module tb_axil_reg_responder;
  logic clk;
  logic rst;

  axil_reg_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  axil_reg_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_axil (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [31:0] rd_q [$];
  logic        b_q  [$];
  logic [31:0] model [8];
  logic [31:0] exp_r;
  logic        exp_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h, required %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) model[a[4:2]][i*8 +: 8] = d[i*8 +: 8];
  endtask

  // Monitor: pops one expectation per completed response handshake.
  always @(negedge clk) begin
    if (!rst && bus.rvalid && bus.rready) begin
      if (rd_q.size() == 0) check("r_unexpected", 32'd1, 32'd0);
      else begin
        exp_r = rd_q.pop_front();
        check("rdata", bus.rdata, exp_r);
        check("rresp", {30'd0, bus.rresp}, 32'd0);
      end
    end
    if (!rst && bus.bvalid && bus.bready) begin
      if (b_q.size() == 0) check("b_unexpected", 32'd1, 32'd0);
      else begin
        exp_b = b_q.pop_front();
        check("bresp", {30'd0, bus.bresp}, 32'd0);
      end
    end
  end

  task automatic w_issue(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    b_q.push_back(1'b1);
    model_write(a, d, s);
    @(negedge clk);
    check("aw_ready", {31'd0, bus.awready}, 32'd1);
    check("w_ready", {31'd0, bus.wready}, 32'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    check("b_latency", {31'd0, bus.bvalid}, 32'd1);
  endtask

  task automatic wait_b_drain();
    for (int i = 0; i < 50 && b_q.size() != 0; i++) @(posedge clk);
    check("b_drain", b_q.size(), 32'd0);
  endtask

  task automatic ar_issue(input logic [4:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    bus.araddr = a; bus.arvalid = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk);
    check("ar_ready", {31'd0, bus.arready}, 32'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    check("r_latency", {31'd0, bus.rvalid}, 32'd1);
  endtask

  task automatic wait_r_drain();
    for (int i = 0; i < 50 && rd_q.size() != 0; i++) @(posedge clk);
    check("r_drain", rd_q.size(), 32'd0);
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] exp);
    ar_issue(a, exp);
    wait_r_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ra;
    logic [31:0] rd;
    logic [3:0]  rs;

    rst = 1'b1;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_awready", {31'd0, bus.awready}, 32'd1);
    check("rst_wready", {31'd0, bus.wready}, 32'd1);
    check("rst_arready", {31'd0, bus.arready}, 32'd1);
    check("rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);

    // 1: simultaneous AW+W, then readback
    w_issue(5'h04, 32'hDEADBEEF, 4'hF);
    wait_b_drain();
    axi_read(5'h04, 32'hDEADBEEF);

    // 2: W three cycles ahead of AW
    @(posedge clk); #1;
    bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    b_q.push_back(1'b1);
    model_write(5'h08, 32'h12345678, 4'hF);
    @(negedge clk);
    check("w2_ready", {31'd0, bus.wready}, 32'd1);
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("w2_wready_low", {31'd0, bus.wready}, 32'd0);
      check("w2_bvalid_low", {31'd0, bus.bvalid}, 32'd0);
      @(posedge clk); #1;
    end
    bus.awaddr = 5'h08; bus.awvalid = 1'b1;
    @(negedge clk);
    check("w2_wready_low", {31'd0, bus.wready}, 32'd0);
    check("w2_awready", {31'd0, bus.awready}, 32'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    @(negedge clk);
    check("w2_bvalid", {31'd0, bus.bvalid}, 32'd1);
    wait_b_drain();
    axi_read(5'h08, 32'h12345678);

    // 3: partial strobe
    w_issue(5'h0C, 32'hFFFFFFFF, 4'hF);
    wait_b_drain();
    w_issue(5'h0C, 32'h00000000, 4'b0101);
    wait_b_drain();
    axi_read(5'h0C, 32'hFF00FF00);

    // 4: backpressure on B and R
    bus.bready = 1'b0;
    w_issue(5'h18, 32'hA5A5A5A5, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_bvalid", {31'd0, bus.bvalid}, 32'd1);
      check("bp_awready", {31'd0, bus.awready}, 32'd0);
      check("bp_wready", {31'd0, bus.wready}, 32'd0);
    end
    @(posedge clk); #1 bus.bready = 1'b1;
    wait_b_drain();
    bus.rready = 1'b0;
    ar_issue(5'h18, model[6]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rvalid", {31'd0, bus.rvalid}, 32'd1);
      check("bp_rdata", bus.rdata, 32'hA5A5A5A5);
      check("bp_arready", {31'd0, bus.arready}, 32'd0);
    end
    @(posedge clk); #1 bus.rready = 1'b1;
    wait_r_drain();

    // 5: read accept on the same edge as write commit returns the old value
    w_issue(5'h10, 32'h1, 4'hF);
    wait_b_drain();
    @(posedge clk); #1;
    bus.awaddr = 5'h10; bus.awvalid = 1'b1;
    bus.wdata = 32'h2; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 5'h10; bus.arvalid = 1'b1;
    b_q.push_back(1'b1);
    rd_q.push_back(32'h1);
    model_write(5'h10, 32'h2, 4'hF);
    @(negedge clk);
    check("same_ar_ready", {31'd0, bus.arready}, 32'd1);
    check("same_aw_ready", {31'd0, bus.awready}, 32'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    wait_b_drain();
    wait_r_drain();
    axi_read(5'h10, 32'h2);

    // scoreboard run over random words, data and strobes
    for (int k = 0; k < 6; k++) begin
      ra = 5'($urandom_range(0, 7) << 2);
      rd = $urandom;
      rs = 4'($urandom_range(1, 15));
      w_issue(ra, rd, rs);
      wait_b_drain();
      axi_read(ra, model[ra[4:2]]);
    end

    // 6: reset while a write response is pending
    bus.bready = 1'b0;
    w_issue(5'h14, 32'h00000077, 4'hF);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    b_q.delete();
    for (int i = 0; i < 8; i++) model[i] = '0;
    @(negedge clk);
    check("rst6_bvalid", {31'd0, bus.bvalid}, 32'd0);
    check("rst6_awready", {31'd0, bus.awready}, 32'd1);
    check("rst6_wready", {31'd0, bus.wready}, 32'd1);
    check("rst6_arready", {31'd0, bus.arready}, 32'd1);
    bus.bready = 1'b1;
    axi_read(5'h14, 32'h0);
    axi_read(5'h04, 32'h0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
